imem_loader: RTL and testbench

- Byte-stream programmer: the write side of the byte-addressed, big-endian instruction memory that the fetch stage reads.
- Accepts a framed byte stream over a valid/ready handshake and writes each payload byte into the instruction memory byte array in arrival order. The first byte of each word lands at the word's lowest address (big-endian).
- Holds the CPU off until a complete, checksum-verified image has been written.

---
 rtl/imem_pkg.sv | 20 ++
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 135 +++++++++++++
 tb/tb_imem_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared sizing and state encoding for the instruction memory and its loader.
// The fetch stage and instruction memory take their size from here as well.
package imem_pkg;

   localparam int IMEM_BYTES     = 128;
   localparam int IMEM_ADDR_W    = 7;
   localparam int IMEM_WC_W      = 6;
   localparam int BYTES_PER_WORD = 4;
   localparam int MAX_WORDS      = IMEM_BYTES / BYTES_PER_WORD;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      DATA = 3'd2,
      CHK  = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input plus instruction-memory write port of the loader.
// master: stream source / memory side; slave: the loader itself.
interface imem_loader_if #(
   parameter int ADDR_W = imem_pkg::IMEM_ADDR_W
);
   logic [7:0]        s_data;
   logic              s_valid;
   logic              s_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;

   modport master (
      output s_data, s_valid,
      input  s_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  s_data, s_valid,
      output s_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory programmer: takes a framed byte stream (count, payload,
// XOR checksum), writes payload bytes in arrival order (big-endian words) and
// keeps the CPU in reset until a verified image is in place.
module imem_loader
   import imem_pkg::*;
#(
   parameter int MEM_BYTES = IMEM_BYTES,
   parameter int ADDR_W    = IMEM_ADDR_W,
   parameter int WC_W      = IMEM_WC_W
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   imem_loader_if.slave    bus,
   output logic            cpu_hold,
   output logic            busy,
   output logic            done,
   output logic            error,
   output logic [WC_W-1:0] word_count
);

   // One extra pointer bit so a full image count (MEM_BYTES) is representable.
   localparam int PTR_W = ADDR_W + 1;
   localparam int WORDS = MEM_BYTES / BYTES_PER_WORD;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [7:0]        csum_q, csum_d;
   logic [WC_W-1:0]   nwords_q, nwords_d;
   logic [WC_W-1:0]   wc_q, wc_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;

   logic              s_ready;
   logic              xfer;
   logic              hdr_ok;
   logic              last_byte;

   assign xfer      = bus.s_valid && s_ready;
   assign hdr_ok    = (bus.s_data != 8'd0) && (32'(bus.s_data) <= 32'(WORDS));
   assign last_byte = ((ptr_q + PTR_W'(1)) == PTR_W'({nwords_q, 2'b00}));

   // State register; reset aborts any load in progress.
   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; start only matters when no load is running.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = HDR;
         HDR:     if (xfer)  state_d = hdr_ok ? DATA : ERR;
         DATA:    if (xfer && last_byte) state_d = CHK;
         CHK:     if (xfer)  state_d = (bus.s_data == csum_q) ? DONE : ERR;
         DONE:    if (start) state_d = HDR;
         ERR:     if (start) state_d = HDR;
         default: state_d = IDLE;
      endcase
   end

   // Status and handshake outputs decoded purely from state.
   always_comb begin
      s_ready  = (state_q == HDR) || (state_q == DATA) || (state_q == CHK);
      busy     = s_ready;
      done     = (state_q == DONE);
      error    = (state_q == ERR);
      cpu_hold = (state_q != DONE);
   end

   // Datapath next values: pointer, checksum, word count and the write port.
   always_comb begin
      ptr_d       = ptr_q;
      csum_d      = csum_q;
      nwords_d    = nwords_q;
      wc_d        = wc_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               ptr_d  = '0;
               csum_d = 8'd0;
               wc_d   = '0;
            end
         end
         HDR: begin
            // Truncation is safe: out-of-range counts never reach DATA.
            if (xfer) nwords_d = WC_W'(bus.s_data);
         end
         DATA: begin
            if (xfer) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = ptr_q[ADDR_W-1:0];
               mem_wdata_d = bus.s_data;
               ptr_d       = ptr_q + PTR_W'(1);
               csum_d      = csum_q ^ bus.s_data;
               if (ptr_q[1:0] == 2'b11) wc_d = wc_q + WC_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Datapath registers, all cleared by reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q       <= '0;
         csum_q      <= 8'd0;
         nwords_q    <= '0;
         wc_q        <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 8'd0;
      end else begin
         ptr_q       <= ptr_d;
         csum_q      <= csum_d;
         nwords_q    <= nwords_d;
         wc_q        <= wc_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.s_ready   = s_ready;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign word_count    = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives framed loads, models the instruction
// memory write port and logs every write for comparison with the frame.
module tb_imem_loader;
   import imem_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       cpu_hold, busy, done, error;
   logic [5:0] word_count;

   imem_loader_if #(.ADDR_W(7)) bus ();

   imem_loader #(.MEM_BYTES(128), .ADDR_W(7), .WC_W(6)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .bus        (bus),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   // Instruction memory write port model plus a write log.
   logic [7:0] imem     [0:127];
   logic [6:0] log_addr [0:1023];
   logic [7:0] log_data [0:1023];
   int         wr_total = 0;

   always @(posedge clk) begin
      if (bus.mem_we === 1'b1) begin
         imem[bus.mem_addr] <= bus.mem_wdata;
         if (wr_total < 1024) begin
            log_addr[wr_total] <= bus.mem_addr;
            log_data[wr_total] <= bus.mem_wdata;
         end
         wr_total <= wr_total + 1;
      end
   end

   int         errors = 0;
   int         checks = 0;
   logic [7:0] frame [0:131];
   int         flen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called right after a falling edge; returns right after the falling edge
   // that follows the accepting rising edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      t = 0;
      bus.s_data  = b;
      bus.s_valid = 1'b1;
      while (bus.s_ready !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) check("s_ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      bus.s_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_frame(input int gap, input int start_at);
      pulse_start();
      for (int i = 0; i < flen; i++) begin
         start = (i == start_at);
         send_byte(frame[i], gap);
         start = 1'b0;
      end
   endtask

   task automatic build_basic(input logic [7:0] ck);
      logic [7:0] basic [0:9];
      basic = '{8'h02, 8'h00, 8'h01, 8'h10, 8'h20, 8'h00, 8'h02, 8'h18, 8'h20, 8'h00};
      for (int i = 0; i < 9; i++) frame[i] = basic[i];
      frame[9] = ck;
      flen = 10;
   endtask

   // Compare the n writes logged since base with payload frame[1..n] at 0..n-1.
   task automatic check_writes(input string tag, input int base, input int n);
      int bad;
      bad = 0;
      check({tag, "_wr_count"}, 32'(wr_total - base), 32'(n));
      for (int k = 0; k < n && (base + k) < 1024; k++) begin
         if (log_addr[base + k] !== 7'(k))      bad++;
         if (log_data[base + k] !== frame[1 + k]) bad++;
         if (imem[k] !== frame[1 + k])            bad++;
      end
      check({tag, "_wr_seq_bad"}, 32'(bad), 32'd0);
   endtask

   initial begin
      int base;
      logic [7:0] ck;

      bus.s_data  = 8'h00;
      bus.s_valid = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_s_ready",   32'(bus.s_ready),   32'd0);
      check("rst_mem_we",    32'(bus.mem_we),    32'd0);
      check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
      check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      check("rst_cpu_hold",  32'(cpu_hold),      32'd1);
      check("rst_busy",      32'(busy),          32'd0);
      check("rst_done",      32'(done),          32'd0);
      check("rst_error",     32'(error),         32'd0);
      check("rst_wc",        32'(word_count),    32'd0);
      reset = 1'b1;
      @(negedge clk);

      // 1. Basic load
      build_basic(8'h0B);
      base = wr_total;
      run_frame(0, -1);
      check_writes("basic", base, 8);
      check("basic_done",     32'(done),       32'd1);
      check("basic_cpu_hold", 32'(cpu_hold),   32'd0);
      check("basic_wc",       32'(word_count), 32'd2);
      check("basic_error",    32'(error),      32'd0);
      check("basic_s_ready",  32'(bus.s_ready), 32'd0);
      $display("load basic: writes=%0d done=%0b error=%0b wc=%0d", wr_total - base, done, error, word_count);

      // 2. Bad checksum, started from DONE
      build_basic(8'h0C);
      base = wr_total;
      pulse_start();
      check("restart_cpu_hold", 32'(cpu_hold), 32'd1);
      check("restart_busy",     32'(busy),     32'd1);
      check("restart_wc",       32'(word_count), 32'd0);
      for (int i = 0; i < flen; i++) send_byte(frame[i], 0);
      check_writes("badck", base, 8);
      check("badck_error",    32'(error),    32'd1);
      check("badck_done",     32'(done),     32'd0);
      check("badck_cpu_hold", 32'(cpu_hold), 32'd1);
      $display("load badck: writes=%0d done=%0b error=%0b wc=%0d", wr_total - base, done, error, word_count);

      // 3. Header out of range
      base = wr_total;
      pulse_start();
      send_byte(8'h00, 0);
      repeat (3) @(negedge clk);
      check("hdr0_error",   32'(error),           32'd1);
      check("hdr0_s_ready", 32'(bus.s_ready),     32'd0);
      check("hdr0_writes",  32'(wr_total - base), 32'd0);
      $display("load hdr00: writes=%0d done=%0b error=%0b", wr_total - base, done, error);
      base = wr_total;
      pulse_start();
      send_byte(8'h21, 0);
      repeat (3) @(negedge clk);
      check("hdr33_error",   32'(error),           32'd1);
      check("hdr33_s_ready", 32'(bus.s_ready),     32'd0);
      check("hdr33_writes",  32'(wr_total - base), 32'd0);
      $display("load hdr21: writes=%0d done=%0b error=%0b", wr_total - base, done, error);

      // 4. Backpressure: three idle cycles between bytes
      build_basic(8'h0B);
      base = wr_total;
      run_frame(3, -1);
      check_writes("bp", base, 8);
      check("bp_wc",   32'(word_count), 32'd2);
      check("bp_done", 32'(done),       32'd1);
      $display("load backpressure: writes=%0d done=%0b error=%0b wc=%0d", wr_total - base, done, error, word_count);

      // 5. Reset after three payload bytes
      base = wr_total;
      pulse_start();
      send_byte(8'h02, 0);
      for (int i = 1; i <= 3; i++) send_byte(frame[i], 0);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("midrst_state",    32'(dut.state_q), 32'(IDLE));
      check("midrst_mem_we",   32'(bus.mem_we),  32'd0);
      check("midrst_busy",     32'(busy),        32'd0);
      check("midrst_cpu_hold", 32'(cpu_hold),    32'd1);
      check("midrst_wc",       32'(word_count),  32'd0);
      repeat (4) @(negedge clk);
      check("midrst_writes", 32'(wr_total - base), 32'd3);
      $display("load reset-abort: writes=%0d busy=%0b", wr_total - base, busy);
      base = wr_total;
      run_frame(0, -1);
      check_writes("after_rst", base, 8);
      check("after_rst_done", 32'(done), 32'd1);
      $display("load after-reset: writes=%0d done=%0b error=%0b wc=%0d", wr_total - base, done, error, word_count);

      // 6. Full image with a stray start pulse mid-payload
      frame[0] = 8'h20;
      ck = 8'h00;
      for (int i = 0; i < 128; i++) begin
         frame[1 + i] = 8'((i * 37 + 5) & 255);
         ck = ck ^ frame[1 + i];
      end
      frame[129] = ck;
      flen = 130;
      base = wr_total;
      run_frame(0, 50);
      check_writes("full", base, 128);
      check("full_last_addr", 32'(log_addr[base + 127]), 32'd127);
      check("full_wc",        32'(word_count), 32'd32);
      check("full_done",      32'(done),       32'd1);
      check("full_error",     32'(error),      32'd0);
      $display("load full: writes=%0d done=%0b error=%0b wc=%0d", wr_total - base, done, error, word_count);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
